// File: rtl/alu_pkg.sv
// Shared types and constants for the decode/execute pipeline: op codes,
// flag bit positions and the active-low hex glyph table.
package alu_pkg;

   localparam int unsigned SEL_W  = 3;
   localparam int unsigned FLAG_W = 4;
   localparam int unsigned SEG_W  = 7;

   typedef enum logic [SEL_W-1:0] {
      OP_SUB = 3'd0,
      OP_ADD = 3'd1,
      OP_OR  = 3'd2,
      OP_AND = 3'd3,
      OP_SRA = 3'd4,
      OP_ROL = 3'd5,
      OP_LT  = 3'd6,
      OP_EQ  = 3'd7
   } op_e;

   // flags vector is {zero, negative, carry, overflow}
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   // segments {a,b,c,d,e,f,g}, active-low; entry 15 first
   localparam logic [15:0][SEG_W-1:0] HEX_GLYPH = {
      7'h38, 7'h30, 7'h42, 7'h31,   // F E d C
      7'h60, 7'h08, 7'h04, 7'h00,   // b A 9 8
      7'h0F, 7'h20, 7'h24, 7'h4C,   // 7 6 5 4
      7'h06, 7'h12, 7'h4F, 7'h01    // 3 2 1 0
   };

endpackage

// File: rtl/decode_execute_pipe_if.sv
// Operand/result handshake bundle between the operand source and the pipe.
interface decode_execute_pipe_if #(
   parameter int unsigned WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] rd;
   logic [3:0]       flags;

   modport master (
      output in_valid, rs, rt, sel, out_ready,
      input  in_ready, out_valid, rd, flags
   );

   modport slave (
      input  in_valid, rs, rt, sel, out_ready,
      output in_ready, out_valid, rd, flags
   );

endinterface

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg
   import alu_pkg::*;
(
   input  logic [3:0]       i_nibble,
   output logic [SEG_W-1:0] o_seg_c
);

   assign o_seg_c = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/decode_execute_pipe.sv
// Registered WIDTH-bit ALU behind a valid/ready handshake, with a scanned
// hex display of the most recently accepted result.
module decode_execute_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned NUM_DIGITS  = WIDTH / 4,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   decode_execute_pipe_if.slave  s_bus,
   output logic [SEG_W-1:0]      o_seg,
   output logic [NUM_DIGITS-1:0] o_an
);

   localparam int unsigned SH_W  = $clog2(WIDTH);
   localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   logic                  w_in_ready;
   logic                  w_accept;
   op_e                   w_op;
   logic                  w_is_sub;
   logic [WIDTH-1:0]      w_b_opnd;
   logic [WIDTH:0]        w_sum;
   logic [SH_W-1:0]       w_sh;
   logic                  w_lt;
   logic [WIDTH-1:0]      w_res;
   logic [FLAG_W-1:0]     w_flags;
   logic [3:0]            w_nibble;
   logic [NUM_DIGITS-1:0] w_an;
   logic [SEG_W-1:0]      w_seg;

   logic                  r_out_valid;
   logic [WIDTH-1:0]      r_rd;
   logic [FLAG_W-1:0]     r_flags;
   logic [WIDTH-1:0]      r_disp;
   logic [CNT_W-1:0]      r_refresh;
   logic [DIG_W-1:0]      r_digit;

   // Result slot is free, or is being drained this very cycle.
   assign w_in_ready = !r_out_valid || s_bus.out_ready;
   assign w_accept   = s_bus.in_valid && w_in_ready;

   assign s_bus.in_ready  = w_in_ready;
   assign s_bus.out_valid = r_out_valid;
   assign s_bus.rd        = r_rd;
   assign s_bus.flags     = r_flags;

   // SUB shares the adder as rs + ~rt + 1, so carry-out is the no-borrow bit.
   assign w_op     = op_e'(s_bus.sel);
   assign w_is_sub = (w_op == OP_SUB);
   assign w_b_opnd = w_is_sub ? ~s_bus.rt : s_bus.rt;
   assign w_sum    = (WIDTH+1)'(s_bus.rs) + (WIDTH+1)'(w_b_opnd) + (WIDTH+1)'(w_is_sub);
   assign w_sh     = s_bus.rs[SH_W-1:0];
   assign w_lt     = $signed(s_bus.rs) < $signed(s_bus.rt);

   always_comb begin
      w_res   = '0;
      w_flags = '0;
      case (w_op)
         OP_SUB, OP_ADD: begin
            w_res           = w_sum[WIDTH-1:0];
            w_flags[FLAG_C] = w_sum[WIDTH];
            w_flags[FLAG_V] = (s_bus.rs[WIDTH-1] == w_b_opnd[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != s_bus.rs[WIDTH-1]);
         end
         OP_OR:   w_res = s_bus.rs | s_bus.rt;
         OP_AND:  w_res = s_bus.rs & s_bus.rt;
         OP_SRA:  w_res = $signed(s_bus.rt) >>> w_sh;
         OP_ROL:  w_res = (s_bus.rt << w_sh) | (s_bus.rt >> (WIDTH - 32'(w_sh)));
         OP_LT:   w_res = WIDTH'(w_lt);
         OP_EQ:   w_res = WIDTH'(s_bus.rs == s_bus.rt);
         default: w_res = '0;
      endcase
      w_flags[FLAG_Z] = (w_res == '0);
      w_flags[FLAG_N] = w_res[WIDTH-1];
   end

   // Result slot and display shadow; a pending result is dropped on reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_rd        <= '0;
         r_flags     <= '0;
         r_disp      <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_rd        <= w_res;
         r_flags     <= w_flags;
         r_disp      <= w_res;
      end else if (s_bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Digit scanner: each digit owns REFRESH_DIV consecutive clocks.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_refresh <= '0;
         r_digit   <= '0;
      end else if (r_refresh == CNT_W'(REFRESH_DIV - 1)) begin
         r_refresh <= '0;
         r_digit   <= (r_digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
      end else begin
         r_refresh <= r_refresh + 1'b1;
      end
   end

   always_comb begin
      w_nibble = '0;
      w_an     = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (r_digit == DIG_W'(i)) begin
            w_nibble = r_disp[4*i +: 4];
            w_an[i]  = 1'b0;
         end
      end
   end

   hex_to_seg u_hex_to_seg (
      .i_nibble (w_nibble),
      .o_seg_c  (w_seg)
   );

   assign o_seg = w_seg;
   assign o_an  = w_an;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Self-checking bench: directed test-plan vectors plus randomized traffic
// checked against an arithmetic reference model.
module tb_decode_execute_pipe;

   localparam int unsigned W  = 16;
   localparam int unsigned ND = 4;
   localparam int unsigned RD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    seg;
   logic [ND-1:0] an;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_execute_pipe_if #(.WIDTH(W)) bus ();

   decode_execute_pipe #(
      .WIDTH       (W),
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD)
   ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .s_bus   (bus),
      .o_seg   (seg),
      .o_an    (an)
   );

   logic [6:0] glyph [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   // Reference ALU built from integer arithmetic on the operand values.
   function automatic void ref_alu(input logic [2:0] s, input logic [W-1:0] a, b,
                                   output logic [W-1:0] r, output logic [3:0] f);
      longint m, ua, ub, sa, sb, t, st;
      int     amt;
      logic   c, v;
      m   = longint'(1) << W;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = (ua >= m/2) ? ua - m : ua;
      sb  = (ub >= m/2) ? ub - m : ub;
      amt = int'(ua % W);
      c = 1'b0; v = 1'b0; t = 0;
      case (s)
         3'd0: begin t = ua - ub; c = (ua >= ub); st = sa - sb; v = (st >= m/2) || (st < -(m/2)); end
         3'd1: begin t = ua + ub; c = (t >= m);   st = sa + sb; v = (st >= m/2) || (st < -(m/2)); end
         3'd2: t = ua | ub;
         3'd3: t = ua & ub;
         3'd4: t = sb >>> amt;
         3'd5: t = (ub << amt) | (ub >> (W - amt));
         3'd6: t = (sa < sb) ? 1 : 0;
         default: t = (ua == ub) ? 1 : 0;
      endcase
      r = W'(t & (m - 1));
      f = {(r == '0), r[W-1], c, v};
   endfunction

   // Model state: result slot, display shadow, clocks since reset.
   logic          m_valid;
   logic [W-1:0]  m_rd, m_disp;
   logic [3:0]    m_flags;
   int unsigned   m_cyc;

   always @(posedge clk) begin : model
      logic [W-1:0] r;
      logic [3:0]   f;
      if (!rst_n) begin
         m_valid <= 1'b0; m_rd <= '0; m_flags <= '0; m_disp <= '0; m_cyc <= 0;
      end else begin
         m_cyc <= m_cyc + 1;
         if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            ref_alu(bus.sel, bus.rs, bus.rt, r, f);
            m_valid <= 1'b1; m_rd <= r; m_flags <= f; m_disp <= r;
         end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] s, input logic [W-1:0] a, b,
                        input logic ordy);
      bus.in_valid  = v;
      bus.sel       = s;
      bus.rs        = a;
      bus.rt        = b;
      bus.out_ready = ordy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 3'd0, '0, '0, 1'b1);
      tick();
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.rd !== 16'h0000) begin n_err++; $display("FAIL reset_rd: got %h want 0000", bus.rd); end
      n_cmp++; if (bus.flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
      n_cmp++; if (an !== 4'b1110) begin n_err++; $display("FAIL reset_an: got %b want 1110", an); end
      n_cmp++; if (seg !== 7'b0000001) begin n_err++; $display("FAIL reset_seg: got %b want 0000001", seg); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_ops();
      logic [2:0]  t_sel [7] = '{3'd1, 3'd0, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [15:0] t_rs  [7] = '{16'h7FFF, 16'h0003, 16'h0005, 16'h0004, 16'h0001, 16'hFFFF, 16'h1234};
      logic [15:0] t_rt  [7] = '{16'h0001, 16'h0005, 16'h0005, 16'h8000, 16'h8001, 16'h0001, 16'h1234};
      logic [15:0] t_rd  [7] = '{16'h8000, 16'hFFFE, 16'h0000, 16'hF800, 16'h0003, 16'h0001, 16'h0001};
      logic [3:0]  t_fl  [7] = '{4'b0101, 4'b0100, 4'b1010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ops_idle_valid: got %b want 0", bus.out_valid); end
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, t_sel[i], t_rs[i], t_rt[i], 1'b1);
         tick();
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ops_valid[%0d]: got %b want 1", i, bus.out_valid); end
         n_cmp++; if (bus.rd !== t_rd[i]) begin n_err++; $display("FAIL ops_rd[%0d]: got %h want %h", i, bus.rd, t_rd[i]); end
         n_cmp++; if (bus.flags !== t_fl[i]) begin n_err++; $display("FAIL ops_flags[%0d]: got %b want %b", i, bus.flags, t_fl[i]); end
      end
      drive(1'b0, 3'd0, '0, '0, 1'b1);
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ops_drain_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_stall();
      drive(1'b1, 3'd2, 16'hA5A5, 16'h0000, 1'b0);
      tick();
      n_cmp++; if (bus.rd !== 16'hA5A5) begin n_err++; $display("FAIL stall_first_rd: got %h want a5a5", bus.rd); end
      drive(1'b1, 3'd1, 16'h0100, 16'h0023, 1'b0);
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
         tick();
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.out_valid); end
         n_cmp++; if (bus.rd !== 16'hA5A5) begin n_err++; $display("FAIL stall_rd[%0d]: got %h want a5a5", i, bus.rd); end
      end
      bus.out_ready = 1'b1;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL swap_valid: got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.rd !== 16'h0123) begin n_err++; $display("FAIL swap_rd: got %h want 0123", bus.rd); end
      drive(1'b0, 3'd0, '0, '0, 1'b1);
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL swap_drain: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_display();
      logic [3:0] e_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0] e_seg [4] = '{7'h38, 7'h12, 7'h08, 7'h4F};
      int d;
      rst_n = 1'b0;
      drive(1'b1, 3'd2, 16'h1A2F, 16'h0000, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      drive(1'b0, 3'd0, '0, '0, 1'b1);
      for (int k = 0; k < 20; k++) begin
         d = ((k + 1) / 4) % 4;
         n_cmp++; if (an !== e_an[d]) begin n_err++; $display("FAIL disp_an[%0d]: got %b want %b", k, an, e_an[d]); end
         n_cmp++; if (seg !== e_seg[d]) begin n_err++; $display("FAIL disp_seg[%0d]: got %b want %b", k, seg, e_seg[d]); end
         tick();
      end
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, 3'd1, 16'h1111, 16'h2222, 1'b0);
      tick();
      drive(1'b0, 3'd0, '0, '0, 1'b0);
      tick();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
      rst_n = 1'b0;
      tick();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.rd !== 16'h0000) begin n_err++; $display("FAIL midrst_rd: got %h want 0000", bus.rd); end
      n_cmp++; if (an !== 4'b1110) begin n_err++; $display("FAIL midrst_an: got %b want 1110", an); end
      n_cmp++; if (seg !== 7'b0000001) begin n_err++; $display("FAIL midrst_seg: got %b want 0000001", seg); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic          held = 1'b0;
      logic [W-1:0]  a;
      int unsigned   d;
      logic [3:0]    e_an;
      logic [6:0]    e_seg;
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            a = W'($urandom);
            drive(($urandom_range(0, 3) != 0), 3'($urandom), a,
                  ($urandom_range(0, 7) == 0) ? a : W'($urandom), 1'b0);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_cmp++; if (bus.in_ready !== (!m_valid || bus.out_ready)) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, bus.in_ready, (!m_valid || bus.out_ready)); end
         held = bus.in_valid && !(!m_valid || bus.out_ready);
         tick();
         n_cmp++; if (bus.out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.out_valid, m_valid); end
         n_cmp++; if (bus.rd !== m_rd) begin n_err++; $display("FAIL rnd_rd[%0d]: got %h want %h", n, bus.rd, m_rd); end
         n_cmp++; if (bus.flags !== m_flags) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b want %b", n, bus.flags, m_flags); end
         d     = (m_cyc / RD) % ND;
         e_an  = ~(4'b0001 << d);
         e_seg = glyph[(m_disp >> (4 * d)) & 16'h000F];
         n_cmp++; if (an !== e_an) begin n_err++; $display("FAIL rnd_an[%0d]: got %b want %b", n, an, e_an); end
         n_cmp++; if (seg !== e_seg) begin n_err++; $display("FAIL rnd_seg[%0d]: got %b want %b", n, seg, e_seg); end
      end
   endtask

   initial begin
      drive(1'b0, 3'd0, '0, '0, 1'b1);
      test_reset();
      test_ops();
      test_stall();
      test_display();
      test_reset_mid_stall();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
